// File: rtl/histogram_peak_finder_pkg.sv
// -----------------------------------------------------------------------------
// histogram_peak_finder_pkg
// Shared definitions for the histogram peak finder and the histogram stage
// that feeds it: default axis sizes, bin count width, FSM state encoding,
// accumulator widths for the optional centroid path and a saturation helper.
// -----------------------------------------------------------------------------
package histogram_peak_finder_pkg;

    // Axis sizes are shared with the histogram stage producing the bins.
    localparam int DEF_IMWIDTH  = 240;
    localparam int DEF_IMHEIGHT = 180;
    localparam int DEF_DATA_W   = 8;

    // Internal bin counters saturate at the axis size, so they need one bit
    // more than the reported 8-bit bin index.
    localparam int IDX_W     = 9;
    localparam int OUT_IDX_W = 8;

    // Centroid accumulators: sum of counts and sum of idx*count.
    localparam int SUM_W     = 16;
    localparam int WSUM_W    = 24;
    localparam int DIV_STEPS = WSUM_W;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_COLLECT  = 3'd1,
        ST_FINALIZE = 3'd2,
        ST_DONE     = 3'd3,
        ST_DIVIDE   = 3'd4
    } state_t;

    // Clamp a divider quotient to the 8-bit bin index range.
    function automatic logic [OUT_IDX_W-1:0] saturate8(input logic [WSUM_W-1:0] q);
        return (q > WSUM_W'(255)) ? 8'hFF : q[OUT_IDX_W-1:0];
    endfunction

endpackage

// File: rtl/histogram_peak_finder_if.sv
// -----------------------------------------------------------------------------
// histogram_peak_finder_if
// Bus bundle between the control/histogram side (master) and the peak finder
// (slave).
//   master drives : start, abort, threshold, xHistogramIn/xValid,
//                   yHistogramIn/yValid
//   slave drives  : per-axis peak index/count, extents (min/max), found,
//                   resultValid, busy
// Build option PEAK_CENTROID_EN adds xCentroid/yCentroid (slave driven).
// -----------------------------------------------------------------------------
interface histogram_peak_finder_if #(
    parameter int DATA_W = histogram_peak_finder_pkg::DEF_DATA_W
);
    localparam int IW = histogram_peak_finder_pkg::OUT_IDX_W;

    logic              start;
    logic              abort;
    logic [DATA_W-1:0] threshold;
    logic [DATA_W-1:0] xHistogramIn;
    logic              xValid;
    logic [DATA_W-1:0] yHistogramIn;
    logic              yValid;

    logic [IW-1:0]     xPeakIdx;
    logic [DATA_W-1:0] xPeakCount;
    logic [IW-1:0]     yPeakIdx;
    logic [DATA_W-1:0] yPeakCount;
    logic [IW-1:0]     xMin;
    logic [IW-1:0]     xMax;
    logic [IW-1:0]     yMin;
    logic [IW-1:0]     yMax;
    logic              found;
    logic              resultValid;
    logic              busy;
`ifdef PEAK_CENTROID_EN
    logic [IW-1:0]     xCentroid;
    logic [IW-1:0]     yCentroid;
`endif

    modport master (
`ifdef PEAK_CENTROID_EN
        input  xCentroid, yCentroid,
`endif
        output start, abort, threshold,
        output xHistogramIn, xValid, yHistogramIn, yValid,
        input  xPeakIdx, xPeakCount, yPeakIdx, yPeakCount,
        input  xMin, xMax, yMin, yMax, found, resultValid, busy
    );

    modport slave (
`ifdef PEAK_CENTROID_EN
        output xCentroid, yCentroid,
`endif
        input  start, abort, threshold,
        input  xHistogramIn, xValid, yHistogramIn, yValid,
        output xPeakIdx, xPeakCount, yPeakIdx, yPeakCount,
        output xMin, xMax, yMin, yMax, found, resultValid, busy
    );

endinterface

// File: rtl/histogram_peak_finder_serial_divider.sv
// -----------------------------------------------------------------------------
// serial_divider
// Restoring divider, 24-bit dividend by 16-bit divisor, one quotient bit per
// clock. Only compiled with PEAK_CENTROID_EN, where it computes the centroid.
//   clk, reset : clock, asynchronous active-low reset
//   start      : one-cycle pulse, loads dividend/divisor
//   dividend   : sum of idx*count
//   divisor    : sum of counts (caller handles zero)
//   done       : one-cycle pulse, 24 cycles after start; quotient valid
//   quotient   : integer quotient, held until the next start
// -----------------------------------------------------------------------------
`ifdef PEAK_CENTROID_EN
module serial_divider
    import histogram_peak_finder_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WSUM_W-1:0] dividend,
    input  logic [SUM_W-1:0]  divisor,
    output logic              done,
    output logic [WSUM_W-1:0] quotient
);
    logic [SUM_W-1:0] rem;
    logic [SUM_W-1:0] dvs;
    logic [4:0]       count;
    logic             running;
    logic [SUM_W:0]   trial;
    logic             fits;

    // The quotient register doubles as the dividend shifter: its MSB feeds the
    // partial remainder and the new quotient bit enters at the LSB.
    assign trial = {rem, quotient[WSUM_W-1]};
    assign fits  = (trial >= {1'b0, dvs});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem      <= '0;
            dvs      <= '0;
            count    <= '0;
            running  <= 1'b0;
            done     <= 1'b0;
            quotient <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                quotient <= dividend;
                rem      <= '0;
                dvs      <= divisor;
                count    <= 5'(DIV_STEPS);
                running  <= 1'b1;
            end else if (running) begin
                quotient <= {quotient[WSUM_W-2:0], fits};
                // A non-fitting trial is below the divisor, so its MSB is 0.
                rem      <= fits ? SUM_W'(trial - {1'b0, dvs}) : trial[SUM_W-1:0];
                count    <= count - 5'd1;
                if (count == 5'd1) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule
`endif

// File: rtl/histogram_peak_finder.sv
// -----------------------------------------------------------------------------
// histogram_peak_finder
// Scans one read pass of the x and y histogram streams and reports, per axis,
// the first maximum bin with its count and the first/last bins at or above a
// threshold latched on start.
//   clk    : system clock
//   reset  : asynchronous, active-low reset
//   bus    : histogram_peak_finder_if.slave
//            in : start, abort, threshold, x/yHistogramIn, x/yValid
//            out: x/yPeakIdx, x/yPeakCount, xMin/xMax, yMin/yMax, found,
//                 resultValid, busy
// Build option PEAK_CENTROID_EN adds per-axis count-weighted centroids
// (xCentroid/yCentroid) computed by two serial dividers in a DIVIDE state.
// -----------------------------------------------------------------------------
module histogram_peak_finder
    import histogram_peak_finder_pkg::*;
#(
    parameter int IMWIDTH  = DEF_IMWIDTH,
    parameter int IMHEIGHT = DEF_IMHEIGHT,
    parameter int DATA_W   = DEF_DATA_W
) (
    input logic                    clk,
    input logic                    reset,
    histogram_peak_finder_if.slave bus
);

    state_t state;
    state_t nextState;

    logic [DATA_W-1:0]    thresholdR;
    logic [IDX_W-1:0]     xIdx;
    logic [IDX_W-1:0]     yIdx;
    logic                 xFull;
    logic                 yFull;
    logic                 clearTrackers;
    logic                 xAccept;
    logic                 yAccept;

    // Per-pass trackers; copied to the outputs in FINALIZE so the reported
    // results stay stable while the next pass collects.
    logic [OUT_IDX_W-1:0] xPeakIdxT;
    logic [OUT_IDX_W-1:0] yPeakIdxT;
    logic [DATA_W-1:0]    xPeakCountT;
    logic [DATA_W-1:0]    yPeakCountT;
    logic [OUT_IDX_W-1:0] xMinT;
    logic [OUT_IDX_W-1:0] xMaxT;
    logic [OUT_IDX_W-1:0] yMinT;
    logic [OUT_IDX_W-1:0] yMaxT;
    logic                 xHit;
    logic                 yHit;

`ifdef PEAK_CENTROID_EN
    logic [SUM_W-1:0]  xSum;
    logic [SUM_W-1:0]  ySum;
    logic [WSUM_W-1:0] xWSum;
    logic [WSUM_W-1:0] yWSum;
    logic              divStart;
    logic              xDivDone;
    logic              yDivDone;
    logic [WSUM_W-1:0] xQuot;
    logic [WSUM_W-1:0] yQuot;
`endif

    assign xFull = (xIdx == IDX_W'(IMWIDTH));
    assign yFull = (yIdx == IDX_W'(IMHEIGHT));

    // start arms (or restarts) a pass from IDLE, DONE or COLLECT; abort wins.
    assign clearTrackers = bus.start && !bus.abort &&
                           (state == ST_IDLE || state == ST_DONE || state == ST_COLLECT);

    // Samples arriving in the restart cycle belong to neither pass.
    assign xAccept = (state == ST_COLLECT) && bus.xValid && !xFull && !clearTrackers && !bus.abort;
    assign yAccept = (state == ST_COLLECT) && bus.yValid && !yFull && !clearTrackers && !bus.abort;

    assign bus.busy = (state == ST_COLLECT) || (state == ST_FINALIZE) || (state == ST_DIVIDE);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        nextState = state;
        if (bus.abort) begin
            nextState = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) nextState = ST_COLLECT;
                end
                ST_COLLECT: begin
                    if (bus.start)          nextState = ST_COLLECT;
                    else if (xFull && yFull) nextState = ST_FINALIZE;
                end
`ifdef PEAK_CENTROID_EN
                ST_FINALIZE: nextState = ST_DIVIDE;
                ST_DIVIDE: begin
                    if (xDivDone && yDivDone) nextState = ST_DONE;
                end
`else
                ST_FINALIZE: nextState = ST_DONE;
`endif
                default: nextState = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------- axis trackers
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            thresholdR  <= '0;
            xIdx        <= '0;
            yIdx        <= '0;
            xPeakIdxT   <= '0;
            yPeakIdxT   <= '0;
            xPeakCountT <= '0;
            yPeakCountT <= '0;
            xMinT       <= '0;
            xMaxT       <= '0;
            yMinT       <= '0;
            yMaxT       <= '0;
            xHit        <= 1'b0;
            yHit        <= 1'b0;
        end else if (clearTrackers) begin
            thresholdR  <= bus.threshold;
            xIdx        <= '0;
            yIdx        <= '0;
            xPeakIdxT   <= '0;
            yPeakIdxT   <= '0;
            xPeakCountT <= '0;
            yPeakCountT <= '0;
            xMinT       <= '0;
            xMaxT       <= '0;
            yMinT       <= '0;
            yMaxT       <= '0;
            xHit        <= 1'b0;
            yHit        <= 1'b0;
        end else begin
            if (xAccept) begin
                xIdx <= xIdx + IDX_W'(1);
                // Strictly greater: ties keep the lowest index.
                if (bus.xHistogramIn > xPeakCountT) begin
                    xPeakCountT <= bus.xHistogramIn;
                    xPeakIdxT   <= xIdx[OUT_IDX_W-1:0];
                end
                if (bus.xHistogramIn >= thresholdR) begin
                    if (!xHit) xMinT <= xIdx[OUT_IDX_W-1:0];
                    xMaxT <= xIdx[OUT_IDX_W-1:0];
                    xHit  <= 1'b1;
                end
            end
            if (yAccept) begin
                yIdx <= yIdx + IDX_W'(1);
                if (bus.yHistogramIn > yPeakCountT) begin
                    yPeakCountT <= bus.yHistogramIn;
                    yPeakIdxT   <= yIdx[OUT_IDX_W-1:0];
                end
                if (bus.yHistogramIn >= thresholdR) begin
                    if (!yHit) yMinT <= yIdx[OUT_IDX_W-1:0];
                    yMaxT <= yIdx[OUT_IDX_W-1:0];
                    yHit  <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------ result outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.xPeakIdx    <= '0;
            bus.xPeakCount  <= '0;
            bus.yPeakIdx    <= '0;
            bus.yPeakCount  <= '0;
            bus.xMin        <= '0;
            bus.xMax        <= '0;
            bus.yMin        <= '0;
            bus.yMax        <= '0;
            bus.found       <= 1'b0;
            bus.resultValid <= 1'b0;
        end else begin
            // High exactly while DONE; start and abort both leave DONE.
            bus.resultValid <= (nextState == ST_DONE);
            if (state == ST_FINALIZE && !bus.abort) begin
                bus.xPeakIdx   <= xPeakIdxT;
                bus.xPeakCount <= xPeakCountT;
                bus.yPeakIdx   <= yPeakIdxT;
                bus.yPeakCount <= yPeakCountT;
                bus.xMin       <= xMinT;
                bus.xMax       <= xMaxT;
                bus.yMin       <= yMinT;
                bus.yMax       <= yMaxT;
                bus.found      <= xHit && yHit;
            end
        end
    end

`ifdef PEAK_CENTROID_EN
    // ---------------------------------------------------- centroid option
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xSum  <= '0;
            ySum  <= '0;
            xWSum <= '0;
            yWSum <= '0;
        end else if (clearTrackers) begin
            xSum  <= '0;
            ySum  <= '0;
            xWSum <= '0;
            yWSum <= '0;
        end else begin
            if (xAccept) begin
                xSum  <= xSum + SUM_W'(bus.xHistogramIn);
                xWSum <= xWSum + WSUM_W'(xIdx[OUT_IDX_W-1:0]) * WSUM_W'(bus.xHistogramIn);
            end
            if (yAccept) begin
                ySum  <= ySum + SUM_W'(bus.yHistogramIn);
                yWSum <= yWSum + WSUM_W'(yIdx[OUT_IDX_W-1:0]) * WSUM_W'(bus.yHistogramIn);
            end
        end
    end

    // Load the dividers on the edge that enters FINALIZE; the sums are final
    // one edge earlier, and the quotients are ready 24 edges later.
    assign divStart = (state == ST_COLLECT) && (nextState == ST_FINALIZE);

    serial_divider u_xDivider (
        .clk      (clk),
        .reset    (reset),
        .start    (divStart),
        .dividend (xWSum),
        .divisor  (xSum),
        .done     (xDivDone),
        .quotient (xQuot)
    );

    serial_divider u_yDivider (
        .clk      (clk),
        .reset    (reset),
        .start    (divStart),
        .dividend (yWSum),
        .divisor  (ySum),
        .done     (yDivDone),
        .quotient (yQuot)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.xCentroid <= '0;
            bus.yCentroid <= '0;
        end else if (state == ST_DIVIDE && !bus.abort && xDivDone && yDivDone) begin
            // An empty axis divides by zero; report 0 instead.
            bus.xCentroid <= (xSum == '0) ? '0 : saturate8(xQuot);
            bus.yCentroid <= (ySum == '0) ? '0 : saturate8(yQuot);
        end
    end
`endif

endmodule
